mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer_if.sv | 13 +
 rtl/mux_scan_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_if.sv
// Downstream word stream of the mux scan sequencer: one captured word plus
// its channel number, transferred on a VALID/READY handshake.
interface mux_scan_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic [2:0]        ch;
  logic              valid;
  logic              ready;

  modport master (output data, output ch, output valid, input ready);
  modport slave  (input data, input ch, input valid, output ready);
endinterface

// File: rtl/mux_scan_sequencer.sv
// Control stage in front of a NUM_CH-to-1 data multiplexer. On START it
// walks the enabled channels in ascending order, captures each multiplexer
// output, streams it downstream with its channel number and accumulates an
// unsigned sum of the sweep. All outputs come straight from registers.
module mux_scan_sequencer #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_CH-1:0]   mask,
  output logic [2:0]          sel,
  input  logic [DATA_W-1:0]   mux_in,
  mux_scan_sequencer_if.master dn,
  output logic                busy,
  output logic                done,
  output logic [DATA_W+2:0]   sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [NUM_CH-1:0]   mask_r, mask_s;
  logic [2:0]          sel_r, sel_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic [2:0]          ch_r, ch_s;
  logic                valid_r, valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [DATA_W+2:0]   sum_r, sum_s;
  logic                cap_s;
  logic [3:0]          next_s;

  // Lowest enabled channel; only meaningful when at least one bit is set.
  function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      r = m[i] ? i[2:0] : r;
    end
    return r;
  endfunction

  // Next enabled channel strictly above cur; bit 3 flags that one exists.
  function automatic logic [3:0] next_ch(input logic [NUM_CH-1:0] m,
                                         input logic [2:0]        cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      r = (m[i] && (i > int'(cur))) ? {1'b1, i[2:0]} : r;
    end
    return r;
  endfunction

  // Next-state and next-output logic for the sweep controller.
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    sel_s   = sel_r;
    data_s  = data_r;
    ch_s    = ch_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    sum_s   = sum_r;
    // A new word may be captured whenever the output slot is free or is
    // being emptied in this very cycle.
    cap_s   = !valid_r || dn.ready;
    next_s  = next_ch(mask_r, sel_r);

    case (state_r)
      IDLE: begin
        if (start) begin
          sum_s = {(DATA_W+3){1'b0}};
          if (|mask) begin
            mask_s  = mask;
            sel_s   = first_ch(mask);
            busy_s  = 1'b1;
            state_s = SCAN;
          end else begin
            // Nothing enabled: the sweep completes immediately.
            done_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SCAN: begin
        if (cap_s) begin
          data_s  = mux_in;
          ch_s    = sel_r;
          valid_s = 1'b1;
          sum_s   = sum_r + {3'b000, mux_in};
          if (next_s[3]) begin
            sel_s = next_s[2:0];
          end else begin
            // Last channel captured; SEL holds until the word drains.
            state_s = DRAIN;
          end
        end else begin
          state_s = SCAN;
        end
      end

      DRAIN: begin
        if (valid_r && dn.ready) begin
          valid_s = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          sel_s   = 3'd0;
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end

      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        sel_s   = 3'd0;
      end
    endcase
  end

  // State and output registers; synchronous reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mask_r  <= {NUM_CH{1'b0}};
      sel_r   <= 3'd0;
      data_r  <= {DATA_W{1'b0}};
      ch_r    <= 3'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {(DATA_W+3){1'b0}};
    end else begin
      state_r <= state_s;
      mask_r  <= mask_s;
      sel_r   <= sel_s;
      data_r  <= data_s;
      ch_r    <= ch_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      sum_r   <= sum_s;
    end
  end

  assign sel      = sel_r;
  assign dn.data  = data_r;
  assign dn.ch    = ch_r;
  assign dn.valid = valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a behavioural 6-to-1 mux feeds the
// DUT, and every observation is compared against hand-derived values.
module tb_mux_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  mask;
  logic [2:0]  sel;
  logic [15:0] mux_in;
  logic        busy;
  logic        done;
  logic [18:0] sum;
  logic [15:0] ch_data [0:5];

  int checks = 0;
  int errors = 0;

  mux_scan_sequencer_if #(.DATA_W(16)) dn_if ();

  mux_scan_sequencer #(.DATA_W(16), .NUM_CH(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mask   (mask),
    .sel    (sel),
    .mux_in (mux_in),
    .dn     (dn_if),
    .busy   (busy),
    .done   (done),
    .sum    (sum)
  );

  // Zero-latency multiplexer model; an out-of-range select reads a marker.
  assign mux_in = (sel < 3'd6) ? ch_data[sel] : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: rising edge, then sample/drive on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"},   32'(sel),          32'd0);
    check({tag, "_data"},  32'(dn_if.data),   32'd0);
    check({tag, "_ch"},    32'(dn_if.ch),     32'd0);
    check({tag, "_valid"}, 32'(dn_if.valid),  32'd0);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_done"},  32'(done),         32'd0);
    check({tag, "_sum"},   32'(sum),          32'd0);
  endtask

  // Sweep with READY held high. chs packs the expected channel order
  // (3 bits each, first in the low bits). restart_at >= 0 pulses a
  // stray START before that capture edge and also during the drain edge.
  task automatic sweep(input string tag, input logic [5:0] m, input int n,
                       input logic [23:0] chs, input logic [18:0] exp_sum,
                       input int restart_at);
    logic [2:0] c;
    logic [2:0] nx;
    dn_if.ready = 1'b1;
    start = 1'b1;
    mask  = m;
    step();
    start = 1'b0;
    mask  = 6'h00;
    check({tag, "_busy_start"},  32'(busy),        32'd1);
    check({tag, "_sel_first"},   32'(sel),         32'(chs[2:0]));
    check({tag, "_valid_start"}, 32'(dn_if.valid), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i == restart_at) begin
        start = 1'b1;
        mask  = 6'h01;
      end
      step();
      start = 1'b0;
      mask  = 6'h00;
      c  = chs[3*i +: 3];
      nx = (i < n - 1) ? chs[3*(i+1) +: 3] : c;
      check({tag, "_valid"}, 32'(dn_if.valid), 32'd1);
      check({tag, "_ch"},    32'(dn_if.ch),    32'(c));
      check({tag, "_data"},  32'(dn_if.data),  32'(ch_data[c]));
      check({tag, "_sel"},   32'(sel),         32'(nx));
      check({tag, "_busy"},  32'(busy),        32'd1);
      check({tag, "_done"},  32'(done),        32'd0);
    end
    if (restart_at >= 0) start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_end_valid"}, 32'(dn_if.valid), 32'd0);
    check({tag, "_end_done"},  32'(done),        32'd1);
    check({tag, "_end_busy"},  32'(busy),        32'd0);
    check({tag, "_end_sel"},   32'(sel),         32'd0);
    check({tag, "_end_sum"},   32'(sum),         32'(exp_sum));
    step();
    check({tag, "_post_done"}, 32'(done),        32'd0);
    check({tag, "_post_busy"}, 32'(busy),        32'd0);
    check({tag, "_post_sum"},  32'(sum),         32'(exp_sum));
  endtask

  task automatic load_ascending();
    for (int i = 0; i < 6; i++) ch_data[i] = 16'(i + 1);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    mask        = 6'h00;
    dn_if.ready = 1'b1;
    load_ascending();
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Full sweep, READY high: channels 0..5, SUM = 21.
    sweep("full", 6'h3F, 6, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 19'd21, -1);

    // Sparse mask: channels 0, 2, 5 only.
    for (int i = 0; i < 6; i++) ch_data[i] = 16'h7777;
    ch_data[0] = 16'h0001;
    ch_data[2] = 16'h0010;
    ch_data[5] = 16'h0100;
    sweep("sparse", 6'b100101, 3, {15'd0, 3'd5, 3'd2, 3'd0}, 19'h00111, -1);

    // Backpressure: READY low for 3 cycles after the first word.
    load_ascending();
    start = 1'b1;
    mask  = 6'h3F;
    step();
    start = 1'b0;
    step();
    check("bp_first_valid", 32'(dn_if.valid), 32'd1);
    check("bp_first_data",  32'(dn_if.data),  32'd1);
    dn_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data",  32'(dn_if.data),  32'd1);
      check("bp_hold_ch",    32'(dn_if.ch),    32'd0);
      check("bp_hold_sel",   32'(sel),         32'd1);
      check("bp_hold_valid", 32'(dn_if.valid), 32'd1);
      check("bp_hold_sum",   32'(sum),         32'd1);
    end
    dn_if.ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      step();
      check("bp_ch",   32'(dn_if.ch),   32'(i));
      check("bp_data", 32'(dn_if.data), 32'(i + 1));
    end
    step();
    check("bp_done", 32'(done), 32'd1);
    check("bp_sum",  32'(sum),  32'd21);
    step();

    // Overflow bound: all inputs at maximum.
    for (int i = 0; i < 6; i++) ch_data[i] = 16'hFFFF;
    sweep("ovf", 6'h3F, 6, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 19'd393210, -1);

    // Empty mask: immediate DONE, SUM cleared, never busy.
    start = 1'b1;
    mask  = 6'h00;
    step();
    start = 1'b0;
    check("empty_done",  32'(done),        32'd1);
    check("empty_busy",  32'(busy),        32'd0);
    check("empty_sum",   32'(sum),         32'd0);
    check("empty_valid", 32'(dn_if.valid), 32'd0);
    step();
    check("empty_done_clr", 32'(done), 32'd0);

    // Stray START mid-sweep and alongside DONE is ignored.
    load_ascending();
    sweep("restart", 6'h3F, 6, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 19'd21, 2);

    // Reset after the third word, then a single-channel sweep.
    start = 1'b1;
    mask  = 6'h3F;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("mid_third_ch", 32'(dn_if.ch), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("midrst");
    ch_data[0] = 16'hABCD;
    sweep("single", 6'h01, 1, {21'd0, 3'd0}, 19'h0ABCD, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
